rr_stream_mux: RTL

//   Parametrised N:1 stream multiplexer with valid/ready handshake on every

---
 rtl/rr_stream_mux.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream multiplexer with fixed-select or round-robin arbitration
// and a single-entry registered output stage.
module rr_stream_mux #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [DATA_W-1:0]   r_out_data;
    logic [SEL_W-1:0]    r_out_ch;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_load_en;
    logic                w_fix_vld;
    logic [NUM_CH-1:0]   w_rot;
    logic [2*NUM_CH-1:0] w_dbl;
    logic [SEL_W-1:0]    w_rr_grant;
    logic [SEL_W-1:0]    w_grant;
    logic                w_grant_vld;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_data;
    logic [SEL_W-1:0]    w_ptr_nxt;

    assign w_load_en = !r_out_valid || out_ready;

    // Fixed-mode validity; an out-of-range select matches no channel and never grants
    always_comb begin
        w_fix_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_fix_vld = w_fix_vld | ((sel == SEL_W'(i)) & in_valid[i]);
        end
    end

    // Round-robin scan: rotate valids so bit 0 is rr_ptr, take the lowest set offset
    always_comb begin
        int off;
        int g;
        w_dbl = {in_valid, in_valid} >> r_rr_ptr;
        w_rot = w_dbl[NUM_CH-1:0];
        off   = 0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                off = j;
            end else begin
                off = off;
            end
        end
        g = int'(r_rr_ptr) + off;
        if (g >= NUM_CH) begin
            g = g - NUM_CH;
        end else begin
            g = g;
        end
        w_rr_grant = SEL_W'(g);
    end

    // Grant selection by mode; in_ready is forced low while reset is held
    always_comb begin
        if (mode) begin
            w_grant     = w_rr_grant;
            w_grant_vld = |in_valid;
        end else begin
            w_grant     = sel;
            w_grant_vld = w_fix_vld;
        end
        w_xfer = w_load_en && w_grant_vld && !rst;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = w_xfer && (w_grant == SEL_W'(i));
        end
    end

    // Data mux driven only by the grant index, not by other channels' valids
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_data = w_data | ({DATA_W{w_grant == SEL_W'(i)}} & in_data[i*DATA_W +: DATA_W]);
        end
        w_ptr_nxt = (w_grant == SEL_W'(NUM_CH - 1)) ? '0 : w_grant + SEL_W'(1);
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_data;
                r_out_ch    <= w_grant;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
            if (w_xfer && mode) begin
                r_rr_ptr <= w_ptr_nxt;
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
